// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard and a registered pending count.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_scoreboard #(
   parameter int XLEN = 64,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   output logic            stall,
   output logic [AW:0]     busy_count
);

   localparam int NREG = 2**AW;

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busyVec;
   logic [NREG-1:0] busyNext;
   logic [AW:0]     popCount;
   logic            wrValid;

   assign wrValid = wr_en && (wr_addr != '0);

   // Clear before set so a same-cycle issue to the written register keeps it pending.
   always_comb begin
      busyNext = busyVec;
      if (wrValid)
         busyNext[wr_addr] = 1'b0;
      if (iss_en && (iss_rd != '0))
         busyNext[iss_rd] = 1'b1;
   end

   always_comb begin
      popCount = '0;
      for (int i = 0; i < NREG; i++)
         popCount = popCount + {{AW{1'b0}}, busyVec[i]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         busyVec    <= '0;
         busy_count <= '0;
      end else begin
         if (wrValid)
            regs[wr_addr] <= wr_data;
         busyVec    <= busyNext;
         busy_count <= popCount;
      end
   end

   always_comb begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      rs2_data = '0;
      rs2_busy = 1'b0;
      if (rs1_addr != '0) begin
         rs1_data = regs[rs1_addr];
         rs1_busy = busyVec[rs1_addr];
`ifdef REGFILE_BYPASS_EN
         if (wrValid && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
            rs1_busy = 1'b0;
         end
`endif
      end
      if (rs2_addr != '0) begin
         rs2_data = regs[rs2_addr];
         rs2_busy = busyVec[rs2_addr];
`ifdef REGFILE_BYPASS_EN
         if (wrValid && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
            rs2_busy = 1'b0;
         end
`endif
      end
   end

   assign stall = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [63:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_rd;
   logic        stall;
   logic [5:0]  busy_count;

   regfile_scoreboard #(.XLEN(64), .AW(5)) dut (
      .clk(clk), .reset(reset),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_rd(iss_rd),
      .stall(stall), .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   // Reference state: register contents, pending flags, and the lagging count.
   logic [63:0] mRegs [32];
   bit          mBusy [32];
   logic [63:0] exp_q [$];
   int          total = 0;
   int          bad = 0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pendingCount();
      int n = 0;
      for (int i = 0; i < 32; i++)
         n += mBusy[i] ? 1 : 0;
      return n;
   endfunction

   function automatic void modelClear();
      for (int i = 0; i < 32; i++) begin
         mRegs[i] = '0;
         mBusy[i] = 1'b0;
      end
   endfunction

   task automatic expectRead(input logic [4:0] a, output logic [63:0] d, output logic b);
      d = (a == 0) ? 64'd0 : mRegs[a];
      b = (a == 0) ? 1'b0 : mBusy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a && a != 0) begin
         d = wr_data;
         b = 1'b0;
      end
`endif
   endtask

   task automatic runCycle(input bit rst, input bit we, input logic [4:0] wa, input logic [63:0] wd,
                           input bit ie, input logic [4:0] ir, input logic [4:0] a1, input logic [4:0] a2);
      logic [63:0] d1, d2;
      logic        b1, b2;
      @(negedge clk);
      reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
      iss_en = ie; iss_rd = ir; rs1_addr = a1; rs2_addr = a2;
      #1;
      expectRead(a1, d1, b1);
      expectRead(a2, d2, b2);
      checkVal("rs1_data", rs1_data, d1);
      checkVal("rs2_data", rs2_data, d2);
      checkVal("rs1_busy", {63'd0, rs1_busy}, {63'd0, b1});
      checkVal("rs2_busy", {63'd0, rs2_busy}, {63'd0, b2});
      checkVal("stall", {63'd0, stall}, {63'd0, b1 | b2});
      if (exp_q.size() > 0)
         checkVal("busy_count", {58'd0, busy_count}, exp_q.pop_front());
      @(posedge clk);
      if (rst) begin
         modelClear();
         exp_q.push_back(64'd0);
      end else begin
         exp_q.push_back(64'(pendingCount()));
         if (we && wa != 0) mRegs[wa] = wd;
         if (we) mBusy[wa] = 1'b0;
         if (ie && ir != 0) mBusy[ir] = 1'b1;
      end
   endtask

   task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
      runCycle(0, 0, 0, 0, 0, 0, a1, a2);
   endtask

   initial begin
      reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
      iss_en = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
      repeat (2) @(posedge clk);
      modelClear();
      exp_q.push_back(64'd0);

      // Reset, then sweep every address on both read ports.
      runCycle(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++)
         idle(5'(2 * i), 5'(2 * i + 1));
      for (int i = 0; i < 32; i++)
         idle(5'(31 - i), 5'(i));

      // Issue, observe pending, write back, observe cleared and count lag.
      runCycle(0, 0, 0, 0, 1, 5, 5, 0);
      idle(5, 0);
      idle(5, 0);
      runCycle(0, 1, 5, 64'hABCD, 0, 0, 5, 5);
      idle(5, 0);
      idle(5, 0);

      // Address zero is immune to writes and issues.
      runCycle(0, 1, 0, 64'hFFFF, 1, 0, 0, 0);
      idle(0, 0);
      idle(0, 0);

      // Same-cycle issue and writeback to one register: data lands, stays pending.
      runCycle(0, 0, 0, 0, 1, 7, 7, 0);
      idle(7, 0);
      runCycle(0, 1, 7, 64'd42, 1, 7, 7, 7);
      idle(7, 7);
      runCycle(0, 1, 7, 64'd1, 0, 0, 7, 0);

      // Writeback visible on rs2 in the write cycle only with bypass.
      runCycle(0, 0, 0, 0, 1, 3, 0, 3);
      idle(0, 3);
      runCycle(0, 1, 3, 64'd99, 0, 0, 0, 3);
      idle(3, 3);

      // Issue chain interrupted by reset.
      for (int i = 1; i <= 3; i++)
         runCycle(0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
      runCycle(1, 1, 2, 64'h55, 1, 4, 1, 2);
      for (int i = 1; i <= 4; i++)
         idle(5'(i), 5'(5 - i));
      idle(0, 0);

      // Random traffic, often confined to low addresses to force collisions.
      for (int n = 0; n < 1500; n++) begin
         int hi;
         hi = ($urandom_range(0, 1) == 0) ? 7 : 31;
         runCycle(($urandom_range(0, 99) == 0),
                  $urandom_range(0, 1),
                  5'($urandom_range(0, hi)),
                  {$urandom, $urandom},
                  $urandom_range(0, 1),
                  5'($urandom_range(0, hi)),
                  5'($urandom_range(0, hi)),
                  5'($urandom_range(0, hi)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
